// File: rtl/gate_sweep_tester_if.sv
// Bundle between the sweep harness and the gate under test plus its status outputs.
// With GATE_SWEEP_FAILCAP_EN defined, the first-failure capture signals are added.
interface gate_sweep_tester_if #(
   parameter int N_IN = 2
);
   logic            start;
   logic [N_IN-1:0] vec;
   logic            dut_s;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_cnt;
`ifdef GATE_SWEEP_FAILCAP_EN
   logic            fail_valid;
   logic [N_IN-1:0] fail_vec;
   logic            fail_obs;

   modport master (
      input  start, dut_s,
      output vec, busy, done, pass, err_cnt, fail_valid, fail_vec, fail_obs
   );
   modport slave (
      output start, dut_s,
      input  vec, busy, done, pass, err_cnt, fail_valid, fail_vec, fail_obs
   );
`else
   modport master (
      input  start, dut_s,
      output vec, busy, done, pass, err_cnt
   );
   modport slave (
      output start, dut_s,
      input  vec, busy, done, pass, err_cnt
   );
`endif
endinterface

// File: rtl/gate_sweep_tester.sv
// Exhaustive sweep of a small combinational gate: drive each vector, settle, compare, count errors.
// Optional first-failure capture is enabled by defining GATE_SWEEP_FAILCAP_EN.
module gate_sweep_tester #(
   parameter int N_IN       = 2,
   parameter int SETTLE_CYC = 1,
   parameter int OP         = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   gate_sweep_tester_if.master bus
);
   localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [N_IN-1:0] VEC_LAST = '1;

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

   state_t          state, state_nxt;
   logic [N_IN-1:0] vec, vec_nxt;
   logic [N_IN:0]   err, err_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            busy, busy_nxt;
   logic            done, done_nxt;
   logic            pass, pass_nxt;
   logic            expect_s;
   logic            mism;

`ifdef GATE_SWEEP_FAILCAP_EN
   logic            fail_valid, fail_valid_nxt;
   logic [N_IN-1:0] fail_vec, fail_vec_nxt;
   logic            fail_obs, fail_obs_nxt;
`endif

   // Reference value of the gate for the vector currently on the pins
   always_comb begin
      case (OP)
         1:       expect_s = |vec;
         2:       expect_s = ^vec;
         3:       expect_s = ~&vec;
         default: expect_s = &vec;
      endcase
   end

   assign mism = bus.dut_s ^ expect_s;

   always_comb begin
      state_nxt = state;
      vec_nxt   = vec;
      err_nxt   = err;
      cnt_nxt   = cnt;
      busy_nxt  = busy;
      done_nxt  = done;
`ifdef GATE_SWEEP_FAILCAP_EN
      fail_valid_nxt = fail_valid;
      fail_vec_nxt   = fail_vec;
      fail_obs_nxt   = fail_obs;
`endif
      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               state_nxt = SETTLE;
               vec_nxt   = '0;
               err_nxt   = '0;
               cnt_nxt   = '0;
               busy_nxt  = 1'b1;
               done_nxt  = 1'b0;
`ifdef GATE_SWEEP_FAILCAP_EN
               fail_valid_nxt = 1'b0;
               fail_vec_nxt   = '0;
               fail_obs_nxt   = 1'b0;
`endif
            end
         end
         SETTLE: begin
            cnt_nxt = cnt + CW'(1);
            if (cnt == CNT_LAST) state_nxt = CHECK;
         end
         CHECK: begin
            if (mism) err_nxt = err + (N_IN+1)'(1);
`ifdef GATE_SWEEP_FAILCAP_EN
            // Only the first mismatch of a sweep is recorded
            if (mism && !fail_valid) begin
               fail_valid_nxt = 1'b1;
               fail_vec_nxt   = vec;
               fail_obs_nxt   = bus.dut_s;
            end
`endif
            if (vec == VEC_LAST) begin
               state_nxt = DONE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
            end else begin
               state_nxt = SETTLE;
               vec_nxt   = vec + N_IN'(1);
               cnt_nxt   = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
      pass_nxt = done_nxt && (err_nxt == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         vec   <= '0;
         err   <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         pass  <= 1'b0;
`ifdef GATE_SWEEP_FAILCAP_EN
         fail_valid <= 1'b0;
         fail_vec   <= '0;
         fail_obs   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         vec   <= vec_nxt;
         err   <= err_nxt;
         cnt   <= cnt_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
         pass  <= pass_nxt;
`ifdef GATE_SWEEP_FAILCAP_EN
         fail_valid <= fail_valid_nxt;
         fail_vec   <= fail_vec_nxt;
         fail_obs   <= fail_obs_nxt;
`endif
      end
   end

   assign bus.vec     = vec;
   assign bus.busy    = busy;
   assign bus.done    = done;
   assign bus.pass    = pass;
   assign bus.err_cnt = err;
`ifdef GATE_SWEEP_FAILCAP_EN
   assign bus.fail_valid = fail_valid;
   assign bus.fail_vec   = fail_vec;
   assign bus.fail_obs   = fail_obs;
`endif
endmodule

// File: tb/tb_gate_sweep_tester.sv
// Scoreboard bench: two harness instances (AND/settle 1, XOR/settle 3) sweep faulty and healthy gates.
module tb_gate_sweep_tester;
   localparam int N  = 2;
   localparam int NV = 1 << N;
   localparam int SCS [2] = '{1, 3};
   localparam int OPS [2] = '{0, 2};

   typedef struct {
      int err;
      bit pass;
      int fvec;
      bit fobs;
      bit fvalid;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit fin [2] = '{0, 0};

   task automatic chk(input string name, input int g, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s[inst %0d] @%0t: got %0d want %0d", name, g, $time, act, exp);
      end
   endtask

   // Gate truth from popcount, independent of bitwise reductions
   function automatic bit ref_fn(input int op, input int v);
      int ones = 0;
      for (int b = 0; b < N; b++) ones += (v >> b) & 1;
      case (op)
         1:       return ones > 0;
         2:       return (ones % 2) == 1;
         3:       return ones != N;
         default: return ones == N;
      endcase
   endfunction

   // fault: 0 healthy, 1 stuck-at-0, 2 stuck-at-1, 3 inverted, 4 per-vector flip mask
   function automatic bit gate_obs(input int op, input int fault, input int flip, input int v);
      case (fault)
         1:       return 1'b0;
         2:       return 1'b1;
         3:       return !ref_fn(op, v);
         4:       return ref_fn(op, v) ^ flip[v];
         default: return ref_fn(op, v);
      endcase
   endfunction

   function automatic exp_t model(input int op, input int fault, input int flip);
      exp_t e = '{err: 0, pass: 1'b0, fvec: 0, fobs: 1'b0, fvalid: 1'b0};
      for (int v = 0; v < NV; v++) begin
         bit o = gate_obs(op, fault, flip, v);
         if (o != ref_fn(op, v)) begin
            if (!e.fvalid) begin
               e.fvalid = 1'b1;
               e.fvec   = v;
               e.fobs   = o;
            end
            e.err++;
         end
      end
      e.pass = (e.err == 0);
      return e;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : inst
      localparam int S   = SCS[g];
      localparam int OPG = OPS[g];

      logic rst_n;
      int   fault;
      int   flip;
      exp_t q [$];

      gate_sweep_tester_if #(.N_IN(N)) bus ();

      gate_sweep_tester #(.N_IN(N), .SETTLE_CYC(S), .OP(OPG)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus.master)
      );

      assign bus.dut_s = gate_obs(OPG, fault, flip, int'(bus.vec));

      // Monitor: tracks sweep progress from observed outputs and scores completed sweeps
      initial begin
         bit bp = 0, dp = 0;
         int cyc = -1;
         exp_t e;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               bp = 0; dp = 0; cyc = -1;
               continue;
            end
            if (bus.busy && !bp) begin
               cyc = 0;
               chk("accept_done_low", g, int'(bus.done), 0);
               chk("accept_err_clr", g, int'(bus.err_cnt), 0);
               chk("accept_pass_low", g, int'(bus.pass), 0);
            end else if (cyc >= 0) begin
               cyc++;
            end
            if (bus.busy && cyc >= 0) chk("vec_step", g, int'(bus.vec), cyc / (S + 1));
            if (dp && !bus.busy) chk("done_held", g, int'(bus.done), 1);
            if (bus.done && !dp) begin
               chk("done_latency", g, cyc, NV * (S + 1));
               chk("done_busy_low", g, int'(bus.busy), 0);
               chk("done_vec_last", g, int'(bus.vec), NV - 1);
               if (q.size() == 0) begin
                  chk("unexpected_done", g, 1, 0);
               end else begin
                  e = q.pop_front();
                  chk("err_cnt", g, int'(bus.err_cnt), e.err);
                  chk("pass", g, int'(bus.pass), int'(e.pass));
`ifdef GATE_SWEEP_FAILCAP_EN
                  chk("fail_valid", g, int'(bus.fail_valid), int'(e.fvalid));
                  if (e.fvalid) begin
                     chk("fail_vec", g, int'(bus.fail_vec), e.fvec);
                     chk("fail_obs", g, int'(bus.fail_obs), int'(e.fobs));
                  end
`endif
               end
               cyc = -1;
            end
            bp = bus.busy;
            dp = bus.done;
         end
      end

      // Stimulus: directed faults, ignored restarts, random flip masks, mid-sweep reset
      initial begin
         bit got;
         rst_n = 1'b0;
         bus.start = 1'b0;
         fault = 0;
         flip = 0;
         repeat (3) @(negedge clk);
         chk("rst_vec", g, int'(bus.vec), 0);
         chk("rst_err", g, int'(bus.err_cnt), 0);
         chk("rst_busy", g, int'(bus.busy), 0);
         chk("rst_done", g, int'(bus.done), 0);
         chk("rst_pass", g, int'(bus.pass), 0);
         rst_n = 1'b1;
         repeat (2) @(negedge clk);

         for (int k = 0; k < 14; k++) begin
            case (k)
               0, 3, 13: fault = 0;
               1, 12:    fault = 1;
               2:        fault = 3;
               4:        fault = 2;
               default:  fault = 4;
            endcase
            flip = int'($urandom_range(0, 15));
            if (k != 12) q.push_back(model(OPG, fault, flip));
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            got = 0;
            if (k == 12) begin
               // Abort with an asynchronous reset once vec reaches 2
               for (int c = 0; c < 100 && !got; c++) begin
                  @(negedge clk);
                  got = (bus.vec == 2'd2);
               end
               chk("reach_vec2", g, int'(got), 1);
               #2 rst_n = 1'b0;
               #1;
               chk("async_rst_vec", g, int'(bus.vec), 0);
               chk("async_rst_err", g, int'(bus.err_cnt), 0);
               chk("async_rst_busy", g, int'(bus.busy), 0);
               chk("async_rst_done", g, int'(bus.done), 0);
               chk("async_rst_pass", g, int'(bus.pass), 0);
               @(negedge clk);
               rst_n = 1'b1;
               @(negedge clk);
            end else begin
               for (int c = 1; c < 200 && !got; c++) begin
                  bus.start = (k == 3 && (c == 3 || c == 5)) || (k == 5 && c == 1);
                  @(negedge clk);
                  got = bus.done;
               end
               bus.start = 1'b0;
               chk("done_timeout", g, int'(got), 1);
               repeat ($urandom_range(0, 3)) @(negedge clk);
            end
         end
         repeat (2) @(negedge clk);
         chk("queue_drained", g, q.size(), 0);
         fin[g] = 1'b1;
      end
   end

   initial begin
      int t = 0;
      while (!(fin[0] && fin[1]) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (!(fin[0] && fin[1])) chk("global_timeout", 0, 1, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
